cmyk_stream_ctrl: RTL and testbench

Flow-control sequencer for the free-running RGB-to-CMYK conversion pipeline in the JPEG viewer print/preview path. The converter cannot stall, so this block accepts an RGB pixel stream with valid/ready and feeds the converter only when the result has guaranteed space downstream. It tracks in-flight pixels with a tag shift register, captures converter results into an output FIFO and presents a CMYK stream with valid/ready. It also counts pixels per frame and marks the last pixel of each frame.

---
 rtl/cmyk_stream_ctrl.sv | 98 +++++++++
 tb/tb_cmyk_stream_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmyk_stream_ctrl.sv
// cmyk_stream_ctrl: credit-based flow control around a non-stalling RGB-to-CMYK converter
module cmyk_stream_ctrl #(
  parameter int COLOR_PRECISION = 8,
  parameter int CONV_LATENCY    = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int FRAME_PIXELS    = 76800
) (
  input  logic                       i_sysclk,
  input  logic                       i_arstn,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  output logic [COLOR_PRECISION-1:0] o_R,
  output logic [COLOR_PRECISION-1:0] o_G,
  output logic [COLOR_PRECISION-1:0] o_B,
  input  logic [COLOR_PRECISION-1:0] i_C,
  input  logic [COLOR_PRECISION-1:0] i_M,
  input  logic [COLOR_PRECISION-1:0] i_Y,
  input  logic [COLOR_PRECISION-1:0] i_K,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [COLOR_PRECISION-1:0] o_C,
  output logic [COLOR_PRECISION-1:0] o_M,
  output logic [COLOR_PRECISION-1:0] o_Y,
  output logic [COLOR_PRECISION-1:0] o_K,
  output logic                       o_last,
  output logic                       o_frame_done
);
  localparam int L   = CONV_LATENCY;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;
  localparam int CW  = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
  localparam int EW  = 4 * COLOR_PRECISION + 1;
  logic [L-1:0]  tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pix_q, pix_d;
  logic          fd_q, fd_d;
  logic [7:0]    inflight;
  logic [EW-1:0] head;
  logic          accept, pop, wr, last_pix;
  assign o_R          = i_R;
  assign o_G          = i_G;
  assign o_B          = i_B;
  assign o_valid      = cnt_q != '0;
  assign head         = o_valid ? mem_q[rd_q] : '0;
  assign {o_C, o_M, o_Y, o_K, o_last} = head;
  assign o_frame_done = fd_q;
  // Credit: buffered plus in-flight pixels must leave room for one more result
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + 8'(tag_v_q[i]);
    o_ready = !i_flush && (8'(cnt_q) + inflight) < 8'(FIFO_DEPTH);
  end
  // Next state for tags, pixel counter, FIFO and frame-done pulse; flush wins over everything
  always_comb begin
    accept   = i_valid & o_ready;
    pop      = o_valid & i_ready;
    wr       = tag_v_q[L-1];
    last_pix = pix_q == CW'(FRAME_PIXELS - 1);
    tag_v_d  = i_flush ? '0 : (tag_v_q << 1) | L'(accept);
    tag_l_d  = i_flush ? '0 : (tag_l_q << 1) | L'(accept & last_pix);
    pix_d    = i_flush ? '0 : !accept ? pix_q : last_pix ? '0 : pix_q + CW'(1);
    wr_d     = i_flush ? '0 : wr_q + AW'(wr);
    rd_d     = i_flush ? '0 : rd_q + AW'(pop);
    cnt_d    = i_flush ? '0 : cnt_q + NW'(wr) - NW'(pop);
    fd_d     = !i_flush && pop && head[0];
    mem_d    = mem_q;
    if (wr && !i_flush) mem_d[wr_q] = {i_C, i_M, i_Y, i_K, tag_l_q[L-1]};
  end
  // State registers, cleared asynchronously so in-flight and buffered pixels are dropped
  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      tag_v_q <= '0;
      tag_l_q <= '0;
      pix_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      tag_v_q <= tag_v_d;
      tag_l_q <= tag_l_d;
      pix_q   <= pix_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_cmyk_stream_ctrl.sv
// tb_cmyk_stream_ctrl: scoreboard bench driving a default-depth and a deep instance in parallel
module tb_cmyk_stream_ctrl;
  localparam int FPA = 5;
  localparam int FPB = 76800;
  logic clk, arstn, flush, valid, rdy_in;
  logic [7:0] r, g, b, cc, cm, cy, ck;
  logic ready_a, valid_a, last_a, fd_a, ready_b, valid_b, last_b, fd_b;
  logic [7:0] or_a, og_a, ob_a, oc_a, om_a, oy_a, ok_a;
  logic [7:0] or_b, og_b, ob_b, oc_b, om_b, oy_b, ok_b;
  logic [31:0] c0, c1, c2;
  logic [32:0] q_a[$], q_b[$];
  int checks = 0, errors = 0, cyc = 0;
  int pc_a = 0, pc_b = 0, acc_a = 0, pops_a = 0, pops_b = 0, lmask_a = 0, fdn_a = 0;
  int first_b = 0, lastc_b = 0;
  logic pend_a = 0, pend_b = 0;

  cmyk_stream_ctrl #(.FRAME_PIXELS(FPA)) dut_a (
    .i_sysclk(clk), .i_arstn(arstn), .i_flush(flush), .i_valid(valid), .o_ready(ready_a),
    .i_R(r), .i_G(g), .i_B(b), .o_R(or_a), .o_G(og_a), .o_B(ob_a),
    .i_C(cc), .i_M(cm), .i_Y(cy), .i_K(ck), .o_valid(valid_a), .i_ready(rdy_in),
    .o_C(oc_a), .o_M(om_a), .o_Y(oy_a), .o_K(ok_a), .o_last(last_a), .o_frame_done(fd_a));

  cmyk_stream_ctrl #(.FIFO_DEPTH(8), .FRAME_PIXELS(FPB)) dut_b (
    .i_sysclk(clk), .i_arstn(arstn), .i_flush(flush), .i_valid(valid), .o_ready(ready_b),
    .i_R(r), .i_G(g), .i_B(b), .o_R(or_b), .o_G(og_b), .o_B(ob_b),
    .i_C(cc), .i_M(cm), .i_Y(cy), .i_K(ck), .o_valid(valid_b), .i_ready(rdy_in),
    .o_C(oc_b), .o_M(om_b), .o_Y(oy_b), .o_K(ok_b), .o_last(last_b), .o_frame_done(fd_b));

  initial clk = 0;
  always #5 clk = ~clk;

  // Converter stand-in: K = 255 - max, C/M/Y = colour - min
  function automatic logic [31:0] conv(input logic [7:0] rr, gg, bb);
    logic [7:0] mx, mn;
    mx = rr > gg ? rr : gg;
    mx = mx > bb ? mx : bb;
    mn = rr < gg ? rr : gg;
    mn = mn < bb ? mn : bb;
    return {rr - mn, gg - mn, bb - mn, 8'hFF - mx};
  endfunction

  // Free-running three-stage converter pipeline
  always @(posedge clk) begin
    c0 <= conv(or_a, og_a, ob_a);
    c1 <= c0;
    c2 <= c1;
  end
  assign {cc, cm, cy, ck} = c2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 0; flush = 0; arstn = 0;
    step(3);
    arstn = 1;
  endtask

  // Scoreboard and monitor for the default-depth instance
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (!arstn) begin
      q_a.delete(); pc_a = 0; pend_a = 0;
    end else begin
      chk("fd_a", fd_a, pend_a);
      if (fd_a) fdn_a++;
      pend_a = 0;
      if (valid_a) chk("stale_a", q_a.size() != 0, 1);
      if (flush) begin
        q_a.delete(); pc_a = 0;
      end else begin
        if (valid_a && rdy_in && q_a.size() != 0) begin
          e = q_a.pop_front();
          chk("data_a", {oc_a, om_a, oy_a, ok_a, last_a}, e);
          if (last_a) lmask_a |= 1 << pops_a;
          pops_a++;
          pend_a = e[0];
        end
        if (valid && ready_a) begin
          q_a.push_back({conv(r, g, b), pc_a == FPA - 1});
          pc_a = pc_a == FPA - 1 ? 0 : pc_a + 1;
          acc_a++;
        end
      end
    end
  end

  // Scoreboard and monitor for the deep instance
  always @(negedge clk) begin
    logic [32:0] e;
    if (!arstn) begin
      q_b.delete(); pc_b = 0; pend_b = 0;
    end else begin
      chk("fd_b", fd_b, pend_b);
      pend_b = 0;
      if (valid_b) chk("stale_b", q_b.size() != 0, 1);
      if (flush) begin
        q_b.delete(); pc_b = 0;
      end else begin
        if (valid_b && rdy_in && q_b.size() != 0) begin
          e = q_b.pop_front();
          chk("data_b", {oc_b, om_b, oy_b, ok_b, last_b}, e);
          if (pops_b == 0) first_b = cyc;
          lastc_b = cyc;
          pops_b++;
          pend_b = e[0];
        end
        if (valid && ready_b) begin
          q_b.push_back({conv(r, g, b), pc_b == FPB - 1});
          pc_b = pc_b == FPB - 1 ? 0 : pc_b + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rdy_in = 1; r = 0; g = 0; b = 0;
    do_reset();
    // reset and idle
    for (int i = 0; i < 10; i++) begin
      chk("idle_rdy", ready_a, 1);
      chk("idle_vld", valid_a, 0);
      chk("idle_fd", fd_a, 0);
      chk("idle_head", {oc_a, om_a, oy_a, ok_a, last_a}, 0);
      step(1);
    end
    chk("idle_rdy_b", ready_b, 1);
    // single pixel latency and value
    r = 8'h10; g = 8'h80; b = 8'h40; valid = 1;
    step(1);
    valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("lat", valid_a, i == 3);
      if (i < 3) step(1);
    end
    chk("px_cmyk", {oc_a, om_a, oy_a, ok_a}, 32'h0070307F);
    chk("px_last", last_a, 0);
    step(6);
    // full throughput on the deep instance
    do_reset();
    pops_b = 0;
    for (int i = 0; i < 100; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); valid = 1;
      chk("tput_rdy", ready_b, 1);
      step(1);
    end
    valid = 0;
    step(30);
    chk("tput_cnt", pops_b, 100);
    chk("tput_gap", lastc_b - first_b, 99);
    // backpressure
    do_reset();
    rdy_in = 0; acc_a = 0; valid = 1;
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      step(1);
    end
    chk("bp_acc", acc_a, 4);
    chk("bp_rdy", ready_a, 0);
    chk("bp_vld", valid_a, 1);
    rdy_in = 1;
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      step(1);
    end
    valid = 0;
    step(20);
    chk("bp_resume", acc_a > 4, 1);
    chk("bp_drain", q_a.size(), 0);
    // frame wrap at five pixels
    do_reset();
    pops_a = 0; lmask_a = 0; fdn_a = 0; acc_a = 0;
    for (int g_ = 0; g_ < 100 && acc_a < 12; g_++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); valid = 1;
      step(1);
    end
    valid = 0;
    step(20);
    chk("wrap_pops", pops_a, 12);
    chk("wrap_last", lmask_a, 32'h210);
    chk("wrap_fd", fdn_a, 2);
    // flush with two in flight and two buffered
    do_reset();
    rdy_in = 0; acc_a = 0;
    for (int g_ = 0; g_ < 50 && acc_a < 4; g_++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); valid = 1;
      step(1);
    end
    valid = 0;
    step(1);
    flush = 1; valid = 1;
    #1;
    chk("fl_rdy", ready_a, 0);
    step(1);
    flush = 0; valid = 0;
    chk("fl_vld", valid_a, 0);
    rdy_in = 1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("fl_quiet", valid_a, 0);
    end
    pops_a = 0; lmask_a = 0; acc_a = 0;
    for (int g_ = 0; g_ < 50 && acc_a < 5; g_++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); valid = 1;
      step(1);
    end
    valid = 0;
    step(20);
    chk("fl_pops", pops_a, 5);
    chk("fl_last", lmask_a, 32'h10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
